// File: rtl/dcpu_pkg.sv
// Shared DCPU encodings: ALU operand selects, forwarding selects and ALU control codes.
package dcpu_pkg;

   localparam logic [1:0] A_SRC_RS    = 2'd0;
   localparam logic [1:0] A_SRC_SHAMT = 2'd1;
   localparam logic [1:0] A_SRC_PC8   = 2'd2;

   localparam logic B_SRC_RT  = 1'b0;
   localparam logic B_SRC_IMM = 1'b1;

   localparam logic [1:0] FWD_RF    = 2'd0;
   localparam logic [1:0] FWD_EXMEM = 2'd1;
   localparam logic [1:0] FWD_MEMWB = 2'd2;

   // ALU control: add/sub go to the adder, shifts to the shifter, lui/slt/sltu to the compare unit.
   localparam logic [3:0] ALUC_ADD  = 4'h0;
   localparam logic [3:0] ALUC_SUB  = 4'h1;
   localparam logic [3:0] ALUC_AND  = 4'h2;
   localparam logic [3:0] ALUC_OR   = 4'h3;
   localparam logic [3:0] ALUC_XOR  = 4'h4;
   localparam logic [3:0] ALUC_NOR  = 4'h5;
   localparam logic [3:0] ALUC_SLL  = 4'h6;
   localparam logic [3:0] ALUC_SRL  = 4'h7;
   localparam logic [3:0] ALUC_SRA  = 4'h8;
   localparam logic [3:0] ALUC_LUI  = 4'h9;
   localparam logic [3:0] ALUC_SLT  = 4'hA;
   localparam logic [3:0] ALUC_SLTU = 4'hB;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard: the ID instruction reads a register that the load now in EX has not yet fetched.
module load_use_detect #(
   parameter int REG_AW = 5
) (
   input  logic              ex_valid,
   input  logic              ex_mem_re,
   input  logic [REG_AW-1:0] ex_rd_addr,
   input  logic              id_valid,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] id_rs_addr,
   input  logic [REG_AW-1:0] id_rt_addr,
   output logic              hazard_stall
);

   logic load_in_ex;
   logic rs_hit;
   logic rt_hit;

   // A load to r0 never produces a value anyone waits for.
   assign load_in_ex   = ex_valid & ex_mem_re & (ex_rd_addr != '0);
   assign rs_hit       = id_uses_rs & (ex_rd_addr == id_rs_addr);
   assign rt_hit       = id_uses_rt & (ex_rd_addr == id_rt_addr);
   assign hazard_stall = load_in_ex & id_valid & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding and selection, bubble insertion on flush or load-use.
module id_ex_stage
   import dcpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int ALUC_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              ex_hold,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_pc,
   input  logic [REG_AW-1:0] id_rs_addr,
   input  logic [REG_AW-1:0] id_rt_addr,
   input  logic [REG_AW-1:0] id_rd_addr,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [15:0]       id_imm16,
   input  logic [4:0]        id_shamt,
   input  logic              id_ext_sign,
   input  logic [1:0]        id_a_src,
   input  logic              id_b_src,
   input  logic [ALUC_W-1:0] id_aluc,
   input  logic              id_reg_we,
   input  logic              id_mem_we,
   input  logic              id_mem_re,
   input  logic [1:0]        fwd_a_sel,
   input  logic [1:0]        fwd_b_sel,
   input  logic [DATA_W-1:0] exmem_fwd_data,
   input  logic [DATA_W-1:0] memwb_fwd_data,
   output logic              hazard_stall,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_alu1,
   output logic [DATA_W-1:0] ex_alu2,
   output logic [ALUC_W-1:0] ex_aluc,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [REG_AW-1:0] ex_rd_addr,
   output logic              ex_reg_we,
   output logic              ex_mem_we,
   output logic              ex_mem_re,
   output logic [DATA_W-1:0] ex_pc
);

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] alu1;
      logic [DATA_W-1:0] alu2;
      logic [ALUC_W-1:0] aluc;
      logic [DATA_W-1:0] store_data;
      logic [REG_AW-1:0] rd_addr;
      logic              reg_we;
      logic              mem_we;
      logic              mem_re;
      logic [DATA_W-1:0] pc;
   } ex_reg_t;

   ex_reg_t           ex_d;
   ex_reg_t           ex_q;
   logic [DATA_W-1:0] rs_f;
   logic [DATA_W-1:0] rt_f;
   logic [DATA_W-1:0] ext;
   logic              take_bubble;

   function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0]        sel,
                                                 input logic [DATA_W-1:0] rf_data,
                                                 input logic [DATA_W-1:0] exmem_data,
                                                 input logic [DATA_W-1:0] memwb_data);
      case (sel)
         FWD_EXMEM: return exmem_data;
         FWD_MEMWB: return memwb_data;
         FWD_RF:    return rf_data;
         default:   return rf_data;
      endcase
   endfunction

   load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
      .ex_valid     (ex_valid),
      .ex_mem_re    (ex_mem_re),
      .ex_rd_addr   (ex_rd_addr),
      .id_valid     (id_valid),
      .id_uses_rs   (id_uses_rs),
      .id_uses_rt   (id_uses_rt),
      .id_rs_addr   (id_rs_addr),
      .id_rt_addr   (id_rt_addr),
      .hazard_stall (hazard_stall)
   );

   assign take_bubble = flush | hazard_stall | ~id_valid;

   always_comb begin
      // NOTE: every field gets a value before any branch so no latch can be inferred.
      ex_d = '0;
      rs_f = fwd_mux(fwd_a_sel, id_rs_data, exmem_fwd_data, memwb_fwd_data);
      rt_f = fwd_mux(fwd_b_sel, id_rt_data, exmem_fwd_data, memwb_fwd_data);
      ext  = {{(DATA_W-16){id_ext_sign & id_imm16[15]}}, id_imm16};

      case (id_a_src)
         A_SRC_SHAMT: ex_d.alu1 = {{(DATA_W-5){1'b0}}, id_shamt};
         A_SRC_PC8:   ex_d.alu1 = id_pc + DATA_W'(8);
         A_SRC_RS:    ex_d.alu1 = rs_f;
         default:     ex_d.alu1 = rs_f;
      endcase

      ex_d.alu2       = (id_b_src == B_SRC_RT) ? rt_f : ext;
      ex_d.valid      = 1'b1;
      ex_d.aluc       = id_aluc;
      ex_d.store_data = rt_f;
      ex_d.rd_addr    = id_rd_addr;
      ex_d.reg_we     = id_reg_we;
      ex_d.mem_we     = id_mem_we;
      ex_d.mem_re     = id_mem_re;
      ex_d.pc         = id_pc;
   end

   // Hold outranks flush: a stalled EX keeps its instruction and the controller re-issues flush.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      if (rst) begin
         ex_q <= '0;
      end else if (!ex_hold) begin
         ex_q <= take_bubble ? '0 : ex_d;
      end
   end

   assign ex_valid      = ex_q.valid;
   assign ex_alu1       = ex_q.alu1;
   assign ex_alu2       = ex_q.alu2;
   assign ex_aluc       = ex_q.aluc;
   assign ex_store_data = ex_q.store_data;
   assign ex_rd_addr    = ex_q.rd_addr;
   assign ex_reg_we     = ex_q.reg_we;
   assign ex_mem_we     = ex_q.mem_we;
   assign ex_mem_re     = ex_q.mem_re;
   assign ex_pc         = ex_q.pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a reference model predicts each EX register state into a scoreboard.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst, flush, ex_hold, id_valid;
   logic [31:0] id_pc, id_rs_data, id_rt_data, exmem_fwd_data, memwb_fwd_data;
   logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
   logic        id_uses_rs, id_uses_rt, id_ext_sign, id_b_src;
   logic [15:0] id_imm16;
   logic [1:0]  id_a_src, fwd_a_sel, fwd_b_sel;
   logic [3:0]  id_aluc;
   logic        id_reg_we, id_mem_we, id_mem_re;

   logic        hazard_stall, ex_valid, ex_reg_we, ex_mem_we, ex_mem_re;
   logic [31:0] ex_alu1, ex_alu2, ex_store_data, ex_pc;
   logic [3:0]  ex_aluc;
   logic [4:0]  ex_rd_addr;

   typedef struct packed {
      logic        valid;
      logic [31:0] alu1;
      logic [31:0] alu2;
      logic [3:0]  aluc;
      logic [31:0] store;
      logic [4:0]  rd;
      logic        reg_we;
      logic        mem_we;
      logic        mem_re;
      logic [31:0] pc;
   } exp_t;

   exp_t sb[$];
   exp_t cur = '0;
   exp_t exp_q, act;
   int   checks = 0;
   int   errors = 0;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .ex_hold(ex_hold), .id_valid(id_valid),
      .id_pc(id_pc), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data),
      .id_rt_data(id_rt_data), .id_imm16(id_imm16), .id_shamt(id_shamt),
      .id_ext_sign(id_ext_sign), .id_a_src(id_a_src), .id_b_src(id_b_src), .id_aluc(id_aluc),
      .id_reg_we(id_reg_we), .id_mem_we(id_mem_we), .id_mem_re(id_mem_re),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .exmem_fwd_data(exmem_fwd_data),
      .memwb_fwd_data(memwb_fwd_data), .hazard_stall(hazard_stall), .ex_valid(ex_valid),
      .ex_alu1(ex_alu1), .ex_alu2(ex_alu2), .ex_aluc(ex_aluc), .ex_store_data(ex_store_data),
      .ex_rd_addr(ex_rd_addr), .ex_reg_we(ex_reg_we), .ex_mem_we(ex_mem_we),
      .ex_mem_re(ex_mem_re), .ex_pc(ex_pc)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf);
      if (sel == 2'd1) return exmem_fwd_data;
      if (sel == 2'd2) return memwb_fwd_data;
      return rf;
   endfunction

   function automatic logic model_haz(input exp_t c);
      return c.valid && c.mem_re && (c.rd != 5'd0) && id_valid &&
             ((id_uses_rs && c.rd == id_rs_addr) || (id_uses_rt && c.rd == id_rt_addr));
   endfunction

   function automatic exp_t model_next(input exp_t c);
      exp_t n;
      logic [31:0] rs_v, rt_v, ext_v;
      if (rst) return '0;
      if (ex_hold) return c;
      if (flush || model_haz(c) || !id_valid) return '0;
      rs_v  = fwd(fwd_a_sel, id_rs_data);
      rt_v  = fwd(fwd_b_sel, id_rt_data);
      ext_v = id_ext_sign ? {{16{id_imm16[15]}}, id_imm16} : {16'h0, id_imm16};
      n.valid  = 1'b1;
      n.alu1   = (id_a_src == 2'd1) ? {27'h0, id_shamt} : (id_a_src == 2'd2) ? id_pc + 32'd8 : rs_v;
      n.alu2   = id_b_src ? ext_v : rt_v;
      n.aluc   = id_aluc;
      n.store  = rt_v;
      n.rd     = id_rd_addr;
      n.reg_we = id_reg_we;
      n.mem_we = id_mem_we;
      n.mem_re = id_mem_re;
      n.pc     = id_pc;
      return n;
   endfunction

   function automatic exp_t actual();
      return '{ex_valid, ex_alu1, ex_alu2, ex_aluc, ex_store_data, ex_rd_addr,
               ex_reg_we, ex_mem_we, ex_mem_re, ex_pc};
   endfunction

   task automatic idle();
      rst = 0; flush = 0; ex_hold = 0; id_valid = 0; id_pc = 0;
      id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_rs_data = 0; id_rt_data = 0; id_imm16 = 0; id_shamt = 0; id_ext_sign = 0;
      id_a_src = 0; id_b_src = 0; id_aluc = 0; id_reg_we = 0; id_mem_we = 0; id_mem_re = 0;
      fwd_a_sel = 0; fwd_b_sel = 0; exmem_fwd_data = 0; memwb_fwd_data = 0;
   endtask

   // Predict the state the coming edge loads, queue it, then advance past the edge.
   task automatic cycle();
      exp_t n;
      n = model_next(cur);
      sb.push_back(n);
      cur = n;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      id_valid = 1; id_rs_data = 32'hDEAD; id_mem_re = 1; id_rd_addr = 5'd3;
      for (int i = 0; i < 2; i++) begin
         cycle();
         exp_q = sb.pop_front(); act = actual(); checks++;
         if (act !== exp_q || act !== '0) begin
            errors++; $display("FAIL reset_%0d: got %h expected %h", i, act, exp_q);
         end
      end
      idle();
      #1;
      checks++;
      if (hazard_stall !== 1'b0) begin
         errors++; $display("FAIL reset_hazard: got %b expected 0", hazard_stall);
      end
   endtask

   task automatic test_addi();
      idle();
      id_valid = 1; id_rs_data = 32'd5; id_imm16 = 16'hFFFF; id_ext_sign = 1; id_b_src = 1;
      id_rd_addr = 5'd9; id_reg_we = 1; id_pc = 32'h0040_0000;
      cycle();
      exp_q = sb.pop_front(); act = actual(); checks++;
      if (act !== exp_q) begin
         errors++; $display("FAIL addi: got %h expected %h", act, exp_q);
      end
      checks++;
      if (ex_alu1 !== 32'd5 || ex_alu2 !== 32'hFFFF_FFFF || ex_valid !== 1'b1) begin
         errors++;
         $display("FAIL addi_fields: got alu1=%h alu2=%h valid=%b expected 5 ffffffff 1",
                  ex_alu1, ex_alu2, ex_valid);
      end
   endtask

   task automatic test_forwarding();
      idle();
      id_valid = 1; id_rs_data = 32'h1111; id_rt_data = 32'h2222;
      fwd_a_sel = 2'd1; exmem_fwd_data = 32'h1234; fwd_b_sel = 2'd2; memwb_fwd_data = 32'hABCD;
      cycle();
      exp_q = sb.pop_front(); act = actual(); checks++;
      if (act !== exp_q) begin
         errors++; $display("FAIL fwd: got %h expected %h", act, exp_q);
      end
      checks++;
      if (ex_alu1 !== 32'h1234 || ex_alu2 !== 32'hABCD || ex_store_data !== 32'hABCD) begin
         errors++;
         $display("FAIL fwd_fields: got %h %h %h expected 1234 abcd abcd",
                  ex_alu1, ex_alu2, ex_store_data);
      end
      fwd_a_sel = 2'd3; fwd_b_sel = 2'd3;
      cycle();
      checks++;
      if (ex_alu1 !== 32'h1111 || ex_store_data !== 32'h2222) begin
         errors++; $display("FAIL fwd_sel3: got %h %h expected 1111 2222", ex_alu1, ex_store_data);
      end
      exp_q = sb.pop_front(); act = actual(); checks++;
      if (act !== exp_q) begin
         errors++; $display("FAIL fwd_sel3_all: got %h expected %h", act, exp_q);
      end
   endtask

   task automatic test_load_use(input logic [4:0] rd, input logic via_rt, input logic exp_haz);
      idle();
      id_valid = 1; id_mem_re = 1; id_reg_we = 1; id_rd_addr = rd; id_aluc = 4'h0;
      cycle();
      exp_q = sb.pop_front(); act = actual(); checks++;
      if (act !== exp_q) begin
         errors++; $display("FAIL lw_rd%0d: got %h expected %h", rd, act, exp_q);
      end
      idle();
      id_valid = 1; id_reg_we = 1; id_rd_addr = 5'd10;
      if (via_rt) begin id_rt_addr = rd; id_uses_rt = 1; end
      else begin id_rs_addr = rd; id_uses_rs = 1; end
      #1;
      checks++;
      if (hazard_stall !== exp_haz || hazard_stall !== model_haz(cur)) begin
         errors++; $display("FAIL hazard_rd%0d: got %b expected %b", rd, hazard_stall, exp_haz);
      end
      cycle();
      exp_q = sb.pop_front(); act = actual(); checks++;
      if (act !== exp_q || ex_valid !== !exp_haz) begin
         errors++; $display("FAIL after_hazard_rd%0d: got %h expected %h", rd, act, exp_q);
      end
      if (exp_haz) begin
         // Retry after the bubble, with the loaded value now coming from MEM/WB.
         fwd_a_sel = 2'd2; fwd_b_sel = 2'd2; memwb_fwd_data = 32'h0000_0077;
         #1;
         checks++;
         if (hazard_stall !== 1'b0) begin
            errors++; $display("FAIL retry_hazard: got %b expected 0", hazard_stall);
         end
         cycle();
         exp_q = sb.pop_front(); act = actual(); checks++;
         if (act !== exp_q || ex_valid !== 1'b1 || ex_store_data !== 32'h77) begin
            errors++; $display("FAIL retry: got %h expected %h", act, exp_q);
         end
      end
   endtask

   task automatic test_flush_hold();
      idle();
      id_valid = 1; id_mem_we = 1; id_rt_data = 32'h5A5A; id_pc = 32'h100;
      cycle();
      exp_q = sb.pop_front(); act = actual(); checks++;
      if (act !== exp_q || ex_mem_we !== 1'b1) begin
         errors++; $display("FAIL store_load: got %h expected %h", act, exp_q);
      end
      flush = 1;
      cycle();
      exp_q = sb.pop_front(); act = actual(); checks++;
      if (act !== exp_q || ex_valid !== 1'b0 || ex_mem_we !== 1'b0) begin
         errors++; $display("FAIL flush: got %h expected %h", act, exp_q);
      end
      flush = 0; id_pc = 32'h104;
      cycle();
      void'(sb.pop_front());
      flush = 1; ex_hold = 1; id_pc = 32'h108; id_rt_data = 32'h0;
      cycle();
      exp_q = sb.pop_front(); act = actual(); checks++;
      if (act !== exp_q || ex_valid !== 1'b1 || ex_mem_we !== 1'b1 || ex_pc !== 32'h104) begin
         errors++; $display("FAIL flush_hold: got %h expected %h", act, exp_q);
      end
   endtask

   task automatic test_operands();
      idle();
      id_valid = 1; id_a_src = 2'd0; id_b_src = 1; id_imm16 = 16'h8000; id_ext_sign = 0;
      id_aluc = 4'h9;
      cycle();
      exp_q = sb.pop_front(); act = actual(); checks++;
      if (act !== exp_q || ex_alu2 !== 32'h0000_8000) begin
         errors++; $display("FAIL lui: got %h expected %h", act, exp_q);
      end
      idle();
      id_valid = 1; id_a_src = 2'd2; id_pc = 32'h0040_0010; id_rd_addr = 5'd31; id_reg_we = 1;
      cycle();
      exp_q = sb.pop_front(); act = actual(); checks++;
      if (act !== exp_q || ex_alu1 !== 32'h0040_0018) begin
         errors++; $display("FAIL jal: got %h expected %h", act, exp_q);
      end
      idle();
      id_valid = 1; id_a_src = 2'd1; id_shamt = 5'd31; id_rs_data = 32'hFFFF_FFFF; id_aluc = 4'h6;
      cycle();
      exp_q = sb.pop_front(); act = actual(); checks++;
      if (act !== exp_q || ex_alu1 !== 32'd31) begin
         errors++; $display("FAIL sll: got %h expected %h", act, exp_q);
      end
      id_a_src = 2'd3; id_rs_data = 32'hCAFE_0001;
      cycle();
      exp_q = sb.pop_front(); act = actual(); checks++;
      if (act !== exp_q || ex_alu1 !== 32'hCAFE_0001) begin
         errors++; $display("FAIL a_src3: got %h expected %h", act, exp_q);
      end
   endtask

   task automatic test_mid_reset();
      idle();
      id_valid = 1; id_reg_we = 1; id_rd_addr = 5'd4; id_rs_data = 32'h99; id_pc = 32'h200;
      cycle();
      void'(sb.pop_front());
      rst = 1; ex_hold = 1;
      cycle();
      exp_q = sb.pop_front(); act = actual(); checks++;
      if (act !== exp_q || act !== '0) begin
         errors++; $display("FAIL mid_reset: got %h expected %h", act, exp_q);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) begin
         idle();
         id_valid       = ($urandom_range(0, 5) != 0);
         flush          = ($urandom_range(0, 7) == 0);
         ex_hold        = ($urandom_range(0, 7) == 0);
         id_pc          = $urandom & 32'hFFFF_FFFC;
         id_rs_addr     = 5'($urandom_range(0, 7));
         id_rt_addr     = 5'($urandom_range(0, 7));
         id_rd_addr     = 5'($urandom_range(0, 7));
         id_uses_rs     = 1'($urandom);
         id_uses_rt     = 1'($urandom);
         id_rs_data     = $urandom;
         id_rt_data     = $urandom;
         id_imm16       = 16'($urandom);
         id_shamt       = 5'($urandom);
         id_ext_sign    = 1'($urandom);
         id_a_src       = 2'($urandom);
         id_b_src       = 1'($urandom);
         id_aluc        = 4'($urandom_range(0, 11));
         id_reg_we      = 1'($urandom);
         id_mem_we      = 1'($urandom);
         id_mem_re      = 1'($urandom);
         fwd_a_sel      = 2'($urandom);
         fwd_b_sel      = 2'($urandom);
         exmem_fwd_data = $urandom;
         memwb_fwd_data = $urandom;
         #1;
         checks++;
         if (hazard_stall !== model_haz(cur)) begin
            errors++; $display("FAIL b2b_hazard_%0d: got %b expected %b", i, hazard_stall, model_haz(cur));
         end
         cycle();
         exp_q = sb.pop_front(); act = actual(); checks++;
         if (act !== exp_q) begin
            errors++; $display("FAIL b2b_%0d: got %h expected %h", i, act, exp_q);
         end
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_addi();
      test_forwarding();
      test_load_use(5'd8, 1'b0, 1'b1);
      test_load_use(5'd0, 1'b0, 1'b0);
      test_load_use(5'd7, 1'b1, 1'b1);
      test_flush_hold();
      test_operands();
      test_mid_reset();
      test_back_to_back();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
